cache_io_ctrl: RTL and testbench
================================

CACHE_IO_CTRL -- requirements
Module: cache_io_ctrl

Interface
REQ-001 Parameter IO_BLOCK_NUM, default 4, number of uncached IO address windows.
REQ-002 Parameter LOOKUP_NUM, default 2, number of independent address-lookup channels (I-side, D-side).
REQ-003 Parameter CMD_DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-004 Parameter GRAN_LSB, default 10, window granularity; address bits below GRAN_LSB are ignored in matching.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rest  in  1  reset, synchronous, active-high.
REQ-007 s0_address  in  32  byte address; word index = s0_address[7:2].
REQ-008 s0_byteEnable  in  4  write byte lanes; 4'b0000 treated as 4'b1111.
REQ-009 s0_read / s0_write  in  1  slave access requests.
REQ-010 s0_writeData  in  32; s0_readData  out  32.
REQ-011 s0_waitRequest  out  1  access not accepted this cycle.
REQ-012 s0_readDataValid  out  1  s0_readData valid.
REQ-013 address  in  32*LOOKUP_NUM  lookup addresses, channel k in bits [32k+31:32k].
REQ-014 isIOAddrBlock  out  LOOKUP_NUM  per-channel IO-window hit.
REQ-015 cmd  out  2; cmd_addr  out  32; cmd_valid  out  1; cmd_ready  in  1  cache command stream.

Function
REQ-016 Register map (word index): 0 CMD, 1 CMD_ADDR, 2+2i BASE_i, 3+2i MASK_i for i<IO_BLOCK_NUM; other indices read 0, writes ignored.
REQ-017 BASE_i bit0 = enable; BASE_i/MASK_i bits [GRAN_LSB-1:1] read 0 and are not stored.
REQ-018 Channel k hits window i when enable_i and ((addr_k ^ BASE_i) & MASK_i)[31:GRAN_LSB]==0; isIOAddrBlock[k] = OR over i, registered, one cycle latency.
REQ-019 Writes to CMD_ADDR, BASE, MASK honour byte enables and take effect the cycle after acceptance.
REQ-020 Write to CMD with writeData[31]=1 pushes {writeData[1:0], CMD_ADDR} into the FIFO; writeData[31]=0 is a no-op.
REQ-021 cmd codes: 0 NOP, 1 FLUSH_ALL, 2 INVALIDATE_ALL, 3 FLUSH_LINE (uses cmd_addr).
REQ-022 CMD push while FIFO full (registered flag): s0_waitRequest=1, write held until a slot frees; pop in same cycle does not admit the push.
REQ-023 All other writes and all reads accepted in the request cycle (s0_waitRequest=0).
REQ-024 Accepted read: s0_readDataValid=1 exactly one cycle later with data; otherwise s0_readDataValid=0, s0_readData=0.
REQ-025 CMD read value: [31]=busy (cmd_valid), [30]=full, [29]=empty, [7:0]=FIFO count.
REQ-026 cmd/cmd_addr/cmd_valid driven from FIFO head; entry popped when cmd_valid & cmd_ready; outputs stable while cmd_valid & !cmd_ready.
REQ-027 s0_read and s0_write both high: write has priority, read ignored.

Reset
REQ-028 rest high: all BASE/MASK/CMD_ADDR = 0, FIFO empty, cmd_valid=0, cmd=0, cmd_addr=0, isIOAddrBlock=0, s0_readDataValid=0, s0_readData=0, s0_waitRequest=0.
REQ-029 rest mid-operation discards in-flight read response and queued commands; no command issued after reset edge.

Structure
REQ-030 Package cache_io_pkg holds cmd codes, register index constants, CMD status bit positions.
REQ-031 FIFO is sub-module cache_cmd_fifo (synchronous, 34-bit, CMD_DEPTH, count/full/empty).

Verification
REQ-032 Reset, read indices 0..10 -> all 0 except CMD=0x2000_0000 (empty), one-cycle readDataValid each.
REQ-033 BASE_0=0x1000_0001, MASK_0=0xFFFF_F000; address ch0=0x1000_0C00, ch1=0x1000_1000 -> isIOAddrBlock=2'b01 one cycle later.
REQ-034 Write MASK_1=0xFFFF_FFFF with byteEnable=4'b0001 -> reads 0x0000_0000 (bits [9:0] unstored); byteEnable=4'b1000 -> 0xFF00_0000.
REQ-035 cmd_ready=0, push 5 FLUSH_LINE with CMD_ADDR=0x40*n -> 5th write stalls (waitRequest=1), CMD reads 0xC000_0004; raise cmd_ready -> commands emitted in order, addr 0x0,0x40,0x80,0xC0,0x100.
REQ-036 cmd_valid held with cmd_ready=0 for 10 cycles -> cmd=1, cmd_addr unchanged; assert rest -> cmd_valid=0 next cycle, FIFO empty.

Source files
------------

// File: rtl/cache_io_pkg.sv
// Shared constants for the cache IO controller: command codes, register map and status layout.
package cache_io_pkg;

  typedef enum logic [1:0] {
    CmdNop           = 2'd0,
    CmdFlushAll      = 2'd1,
    CmdInvalidateAll = 2'd2,
    CmdFlushLine     = 2'd3
  } cmd_e;

  localparam int unsigned RegCmd     = 0;
  localparam int unsigned RegCmdAddr = 1;
  localparam int unsigned RegBase0   = 2;

  localparam int unsigned StatBusyBit  = 31;
  localparam int unsigned StatFullBit  = 30;
  localparam int unsigned StatEmptyBit = 29;

  // FIFO entry is {cmd[1:0], cmd_addr[31:0]}
  localparam int unsigned CmdEntryW = 34;

  function automatic int unsigned base_idx(input int unsigned i);
    return RegBase0 + 2 * i;
  endfunction

  function automatic int unsigned mask_idx(input int unsigned i);
    return RegBase0 + 2 * i + 1;
  endfunction

  // An all-zero byte enable means a full-word write
  function automatic logic [31:0] be_expand(input logic [3:0] be);
    logic [3:0] eff;
    eff = (be == 4'b0000) ? 4'b1111 : be;
    return {{8{eff[3]}}, {8{eff[2]}}, {8{eff[1]}}, {8{eff[0]}}};
  endfunction

endpackage

// File: rtl/cache_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; head entry is always visible on head_data.
module cache_cmd_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 34
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic                   push,
  input  logic [Width-1:0]       push_data,
  input  logic                   pop,
  output logic [Width-1:0]       head_data,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full      = (count_q == CntW'(Depth));
  assign empty     = (count_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rest) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: nothing reads it while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cache_io_ctrl.sv
// Cache IO controller: slave register file for uncached IO windows, per-channel window
// lookup, and a queued cache-maintenance command stream.
module cache_io_ctrl
  import cache_io_pkg::*;
#(
  parameter int unsigned IO_BLOCK_NUM = 4,
  parameter int unsigned LOOKUP_NUM   = 2,
  parameter int unsigned CMD_DEPTH    = 4,
  parameter int unsigned GRAN_LSB     = 10
) (
  input  logic                    clk,
  input  logic                    rest,
  input  logic [31:0]             s0_address,
  input  logic [3:0]              s0_byteEnable,
  input  logic                    s0_read,
  input  logic                    s0_write,
  input  logic [31:0]             s0_writeData,
  output logic [31:0]             s0_readData,
  output logic                    s0_waitRequest,
  output logic                    s0_readDataValid,
  input  logic [32*LOOKUP_NUM-1:0] address,
  output logic [LOOKUP_NUM-1:0]   isIOAddrBlock,
  output logic [1:0]              cmd,
  output logic [31:0]             cmd_addr,
  output logic                    cmd_valid,
  input  logic                    cmd_ready
);

  localparam int unsigned CntW = $clog2(CMD_DEPTH) + 1;
  // Bits below the window granularity are never stored; base keeps bit 0 as its enable
  localparam logic [31:0] MaskKeep = ~((32'd1 << GRAN_LSB) - 32'd1);
  localparam logic [31:0] BaseKeep = MaskKeep | 32'd1;

  logic [31:0] base_q [IO_BLOCK_NUM];
  logic [31:0] base_d [IO_BLOCK_NUM];
  logic [31:0] mask_q [IO_BLOCK_NUM];
  logic [31:0] mask_d [IO_BLOCK_NUM];
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [LOOKUP_NUM-1:0] hit_q, hit_d;
  logic        rd_valid_q;
  logic [31:0] rd_data_q, rd_val;

  logic [5:0]  widx;
  logic [31:0] wmask, wmerged_src;
  logic        cmd_push_req, wr_acc, rd_acc, push, pop;

  logic [CmdEntryW-1:0] head;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_full, fifo_empty;

  assign widx         = s0_address[7:2];
  assign wmask        = be_expand(s0_byteEnable);
  assign wmerged_src  = s0_writeData & wmask;
  assign cmd_push_req = s0_write & (32'(widx) == RegCmd) & s0_writeData[31];

  // Full is registered, so a pop in this cycle cannot admit a stalled push
  assign s0_waitRequest = ~rest & cmd_push_req & fifo_full;
  assign wr_acc         = s0_write & ~s0_waitRequest;
  assign rd_acc         = s0_read & ~s0_write;
  assign push           = cmd_push_req & ~s0_waitRequest;
  assign pop            = cmd_valid & cmd_ready;

  cache_cmd_fifo #(
    .Depth(CMD_DEPTH),
    .Width(CmdEntryW)
  ) u_cmd_fifo (
    .clk      (clk),
    .rest     (rest),
    .push     (push),
    .push_data({s0_writeData[1:0], cmd_addr_q}),
    .pop      (pop),
    .head_data(head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign cmd_valid = ~fifo_empty;
  assign cmd       = fifo_empty ? 2'b00 : head[CmdEntryW-1:32];
  assign cmd_addr  = fifo_empty ? 32'd0 : head[31:0];

  always_comb begin
    cmd_addr_d = cmd_addr_q;
    base_d     = base_q;
    mask_d     = mask_q;
    if (wr_acc) begin
      if (32'(widx) == RegCmdAddr) cmd_addr_d = (cmd_addr_q & ~wmask) | wmerged_src;
      for (int unsigned i = 0; i < IO_BLOCK_NUM; i++) begin
        if (32'(widx) == base_idx(i)) base_d[i] = ((base_q[i] & ~wmask) | wmerged_src) & BaseKeep;
        if (32'(widx) == mask_idx(i)) mask_d[i] = ((mask_q[i] & ~wmask) | wmerged_src) & MaskKeep;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (32'(widx) == RegCmd) begin
      rd_val[StatBusyBit]  = cmd_valid;
      rd_val[StatFullBit]  = fifo_full;
      rd_val[StatEmptyBit] = fifo_empty;
      rd_val[7:0]          = 8'(fifo_count);
    end else if (32'(widx) == RegCmdAddr) begin
      rd_val = cmd_addr_q;
    end
    for (int unsigned i = 0; i < IO_BLOCK_NUM; i++) begin
      if (32'(widx) == base_idx(i)) rd_val = base_q[i];
      if (32'(widx) == mask_idx(i)) rd_val = mask_q[i];
    end
  end

  always_comb begin
    hit_d = '0;
    for (int unsigned k = 0; k < LOOKUP_NUM; k++) begin
      for (int unsigned i = 0; i < IO_BLOCK_NUM; i++) begin
        if (base_q[i][0] && (((address[32*k +: 32] ^ base_q[i]) & mask_q[i] & MaskKeep) == '0)) begin
          hit_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      for (int unsigned i = 0; i < IO_BLOCK_NUM; i++) begin
        base_q[i] <= '0;
        mask_q[i] <= '0;
      end
      cmd_addr_q <= '0;
      hit_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      base_q     <= base_d;
      mask_q     <= mask_d;
      cmd_addr_q <= cmd_addr_d;
      hit_q      <= hit_d;
      rd_valid_q <= rd_acc;
      rd_data_q  <= rd_acc ? rd_val : 32'd0;
    end
  end

  assign isIOAddrBlock    = hit_q;
  assign s0_readDataValid = rd_valid_q;
  assign s0_readData      = rd_data_q;

endmodule

// File: tb/tb_cache_io_ctrl.sv
// Self-checking bench for cache_io_ctrl: directed scenarios plus randomized register,
// lookup and command traffic checked against a register-map level model.
module tb_cache_io_ctrl;
  import cache_io_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned NL = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned G  = 10;

  logic          clk = 1'b0;
  logic          rest = 1'b1;
  logic [31:0]   s0_address = '0;
  logic [3:0]    s0_byteEnable = 4'hF;
  logic          s0_read = 1'b0;
  logic          s0_write = 1'b0;
  logic [31:0]   s0_writeData = '0;
  logic [31:0]   s0_readData;
  logic          s0_waitRequest;
  logic          s0_readDataValid;
  logic [32*NL-1:0] address = '0;
  logic [NL-1:0] isIOAddrBlock;
  logic [1:0]    cmd;
  logic [31:0]   cmd_addr;
  logic          cmd_valid;
  logic          cmd_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] m_base [NB];
  logic [31:0] m_mask [NB];
  logic [31:0] m_cmd_addr;
  logic [33:0] m_q [$];

  cache_io_ctrl #(
    .IO_BLOCK_NUM(NB),
    .LOOKUP_NUM  (NL),
    .CMD_DEPTH   (D),
    .GRAN_LSB    (G)
  ) dut (
    .clk             (clk),
    .rest            (rest),
    .s0_address      (s0_address),
    .s0_byteEnable   (s0_byteEnable),
    .s0_read         (s0_read),
    .s0_write        (s0_write),
    .s0_writeData    (s0_writeData),
    .s0_readData     (s0_readData),
    .s0_waitRequest  (s0_waitRequest),
    .s0_readDataValid(s0_readDataValid),
    .address         (address),
    .isIOAddrBlock   (isIOAddrBlock),
    .cmd             (cmd),
    .cmd_addr        (cmd_addr),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_base[i] = '0;
      m_mask[i] = '0;
    end
    m_cmd_addr = '0;
    m_q.delete();
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be == 4'b0000 || be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] low, v;
    int i;
    low = (32'd1 << G) - 32'd1;
    if (idx == 0) begin
      if (d[31]) m_q.push_back({d[1:0], m_cmd_addr});
    end else if (idx == 1) begin
      m_cmd_addr = merge(m_cmd_addr, d, be);
    end else if (idx >= 2 && idx < 2 + 2 * NB) begin
      i = (idx - 2) / 2;
      if (idx % 2 == 0) begin
        v = merge(m_base[i], d, be);
        m_base[i] = (v & ~low) | (v & 32'd1);
      end else begin
        v = merge(m_mask[i], d, be);
        m_mask[i] = v & ~low;
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    int n;
    n = m_q.size();
    if (idx == 0) return {n != 0, n == D, n == 0, 21'b0, 8'(n)};
    if (idx == 1) return m_cmd_addr;
    if (idx >= 2 && idx < 2 + 2 * NB) return (idx % 2 == 0) ? m_base[(idx-2)/2] : m_mask[(idx-2)/2];
    return 32'd0;
  endfunction

  function automatic logic [NL-1:0] exp_hit(input logic [32*NL-1:0] a);
    logic [NL-1:0] h;
    h = '0;
    for (int k = 0; k < NL; k++)
      for (int i = 0; i < NB; i++)
        if (m_base[i][0] && ((((a[32*k +: 32] ^ m_base[i]) & m_mask[i]) >> G) == 32'd0)) h[k] = 1'b1;
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int idx, input logic [31:0] d, input logic [3:0] be);
    s0_address = 32'(idx) << 2;
    s0_writeData = d;
    s0_byteEnable = be;
    s0_write = 1'b1;
    #1;
    chk("write_wait", 32'(s0_waitRequest), 32'(idx == 0 && d[31] && m_q.size() == D));
    @(posedge clk);
    model_write(idx, d, be);
    #1;
    s0_write = 1'b0;
    s0_byteEnable = 4'hF;
  endtask

  task automatic do_read(input int idx);
    logic [31:0] exp;
    s0_address = 32'(idx) << 2;
    s0_read = 1'b1;
    exp = model_read(idx);
    tick();
    chk("read_valid", 32'(s0_readDataValid), 32'd1);
    chk("read_data", s0_readData, exp);
    s0_read = 1'b0;
    tick();
    chk("read_valid_drop", 32'(s0_readDataValid), 32'd0);
    chk("read_data_idle", s0_readData, 32'd0);
  endtask

  task automatic lookup(input logic [31:0] a0, input logic [31:0] a1);
    address = {a1, a0};
    tick();
    chk("hit", 32'(isIOAddrBlock), 32'(exp_hit(address)));
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int g = 0; g < 4 * D && m_q.size() > 0; g++) begin
      chk("drain_valid", 32'(cmd_valid), 32'd1);
      chk("drain_cmd", 32'(cmd), 32'(m_q[0][33:32]));
      chk("drain_addr", cmd_addr, m_q[0][31:0]);
      @(posedge clk);
      void'(m_q.pop_front());
      #1;
    end
    cmd_ready = 1'b0;
    chk("drain_empty", 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    int op, idx, bi;
    logic [31:0] d, a0, a1;
    logic [3:0] be;

    model_reset();
    tick();
    tick();
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_cmd_addr", cmd_addr, 32'd0);
    chk("rst_hit", 32'(isIOAddrBlock), 32'd0);
    chk("rst_rdv", 32'(s0_readDataValid), 32'd0);
    chk("rst_rdata", s0_readData, 32'd0);
    chk("rst_wait", 32'(s0_waitRequest), 32'd0);
    rest = 1'b0;
    tick();

    for (int i = 0; i <= 10; i++) do_read(i);
    do_read(0);

    // Window 0 covers 0x1000_0000..0x1000_0FFF
    do_write(2, 32'h1000_0001, 4'hF);
    do_write(3, 32'hFFFF_F000, 4'hF);
    lookup(32'h1000_0C00, 32'h1000_1000);
    chk("win0_hit", 32'(isIOAddrBlock), 32'h1);

    do_write(5, 32'hFFFF_FFFF, 4'b0001);
    do_read(5);
    do_write(5, 32'hFFFF_FFFF, 4'b1000);
    do_read(5);
    chk("mask1_const", model_read(5), 32'hFF00_0000);
    do_write(4, 32'hFFFF_FFFF, 4'b0000);
    do_read(4);

    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 2);
      idx = $urandom_range(0, 15);
      d = $urandom;
      be = 4'($urandom);
      if (op == 0) begin
        if (idx == 0 && m_q.size() >= D) d[31] = 1'b0;
        do_write(idx, d, be);
      end else if (op == 1) begin
        do_read(idx);
      end else begin
        bi = $urandom_range(0, NB - 1);
        a0 = $urandom_range(0, 1) ? (m_base[bi] ^ ($urandom & ~m_mask[bi])) : $urandom;
        bi = $urandom_range(0, NB - 1);
        a1 = $urandom_range(0, 1) ? (m_base[bi] ^ ($urandom & ~m_mask[bi])) : $urandom;
        lookup(a0, a1);
      end
    end
    drain();

    for (int n = 0; n < 4; n++) begin
      do_write(1, 32'h40 * n, 4'hF);
      do_write(0, 32'h8000_0000 | 32'(CmdFlushLine), 4'hF);
    end
    do_read(0);
    chk("full_status", model_read(0), 32'hC000_0004);
    do_write(1, 32'h100, 4'hF);
    s0_address = 32'(RegCmd) << 2;
    s0_writeData = 32'h8000_0000 | 32'(CmdFlushLine);
    s0_write = 1'b1;
    #1;
    chk("stall", 32'(s0_waitRequest), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall_hold", 32'(s0_waitRequest), 32'd1);
      chk("stall_head", cmd_addr, m_q[0][31:0]);
    end
    cmd_ready = 1'b1;
    @(posedge clk);
    void'(m_q.pop_front());
    #1;
    chk("unstall", 32'(s0_waitRequest), 32'd0);
    chk("unstall_head", cmd_addr, m_q[0][31:0]);
    @(posedge clk);
    void'(m_q.pop_front());
    model_write(0, s0_writeData, 4'hF);
    #1;
    s0_write = 1'b0;
    drain();

    do_write(1, 32'h1234_5000, 4'hF);
    do_write(0, 32'h8000_0000 | 32'(CmdFlushAll), 4'hF);
    do_write(1, 32'hABC0_0000, 4'hF);
    do_write(0, 32'h8000_0000 | 32'(CmdInvalidateAll), 4'hF);
    do_write(2, 32'h1000_0001, 4'hF);
    do_write(3, 32'hFFFF_F000, 4'hF);
    lookup(32'h1000_0400, 32'h1000_0800);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_valid", 32'(cmd_valid), 32'd1);
      chk("hold_cmd", 32'(cmd), 32'(m_q[0][33:32]));
      chk("hold_addr", cmd_addr, m_q[0][31:0]);
    end

    s0_address = 32'd4;
    s0_read = 1'b1;
    rest = 1'b1;
    tick();
    s0_read = 1'b0;
    model_reset();
    chk("mid_rst_rdv", 32'(s0_readDataValid), 32'd0);
    chk("mid_rst_rdata", s0_readData, 32'd0);
    chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'd0);
    chk("mid_rst_addr", cmd_addr, 32'd0);
    rest = 1'b0;
    cmd_ready = 1'b1;
    tick();
    chk("post_rst_valid", 32'(cmd_valid), 32'd0);
    chk("post_rst_hit", 32'(isIOAddrBlock), 32'(exp_hit(address)));
    cmd_ready = 1'b0;
    do_read(0);
    do_read(1);
    do_read(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
